cprv_dmem: RTL

Data memory responder for the cprv64 core. It terminates the dmem request channel driven by the memory stage and executes byte, half, word and doubleword stores directly. Loads return LSB-aligned 64-bit data on a valid/ready response channel one cycle after acceptance. The block sits between the memory stage and a single-port word-organised storage array and holds at most one load response at a time.

---
 rtl/cprv_dmem_pkg.sv | 29 ++
 rtl/cprv_dmem_lane_align.sv | 62 ++++++
 rtl/cprv_dmem.sv | 119 +++++++++++
 3 files changed

// File: rtl/cprv_dmem_pkg.sv
// Shared types and helpers for the cprv64 data memory responder.
package cprv_dmem_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2,
      SZ_D = 2'd3
   } size_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RESP = 1'b1
   } state_e;

   // Byte-lane enables for an access of the given size at the given offset (upper lanes drop off).
   function automatic logic [7:0] byte_mask(input logic [1:0] size, input logic [2:0] off);
      logic [7:0] base;
      case (size)
         2'd0:    base = 8'h01;
         2'd1:    base = 8'h03;
         2'd2:    base = 8'h0F;
         2'd3:    base = 8'hFF;
         default: base = 8'hFF;
      endcase
      return base << off;
   endfunction

endpackage

// File: rtl/cprv_dmem_lane_align.sv
// Combinational lane steering for cprv_dmem: byte mask, store shift, load extract, misalign flag.
// CPRV_DMEM_MISALIGN_CHK_EN enables misalign detection; otherwise offsets snap to natural alignment.
module cprv_dmem_lane_align
   import cprv_dmem_pkg::*;
(
   input  logic [2:0]  off_raw,
   input  size_e       size,
   input  logic [63:0] wdata,
   input  logic [63:0] rword,
   output logic [7:0]  mask,
   output logic [63:0] wdata_sh,
   output logic [63:0] rdata_al,
   output logic        misalign
);

   logic [2:0]  align_msk_s;
   logic [63:0] size_msk_s;
   logic [2:0]  off_s;
   logic [5:0]  sh_s;

   // Offset bits that must be zero, and the load data width, for each access size
   always_comb begin
      align_msk_s = 3'b111;
      size_msk_s  = 64'hFFFF_FFFF_FFFF_FFFF;
      case (size)
         SZ_B: begin
            align_msk_s = 3'b000;
            size_msk_s  = 64'h0000_0000_0000_00FF;
         end
         SZ_H: begin
            align_msk_s = 3'b001;
            size_msk_s  = 64'h0000_0000_0000_FFFF;
         end
         SZ_W: begin
            align_msk_s = 3'b011;
            size_msk_s  = 64'h0000_0000_FFFF_FFFF;
         end
         SZ_D: begin
            align_msk_s = 3'b111;
            size_msk_s  = 64'hFFFF_FFFF_FFFF_FFFF;
         end
         default: begin
            align_msk_s = 3'b111;
            size_msk_s  = 64'hFFFF_FFFF_FFFF_FFFF;
         end
      endcase
   end

`ifdef CPRV_DMEM_MISALIGN_CHK_EN
   assign off_s    = off_raw;
   assign misalign = (off_raw & align_msk_s) != 3'b000;
`else
   assign off_s    = off_raw & ~align_msk_s;
   assign misalign = 1'b0;
`endif

   assign sh_s     = {off_s, 3'b000};
   assign mask     = byte_mask(size, off_s);
   assign wdata_sh = wdata << sh_s;
   assign rdata_al = (rword >> sh_s) & size_msk_s;

endmodule

// File: rtl/cprv_dmem.sv
// cprv64 data memory responder: direct stores, one-deep registered load response channel.
// Misalign checking is built in when CPRV_DMEM_MISALIGN_CHK_EN is defined.
module cprv_dmem
   import cprv_dmem_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH      = 1024
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  valid_dmem_i,
   output logic                  ready_dmem_o,
   input  logic [DATA_WIDTH-1:0] addr_dmem_i,
   input  logic [DATA_WIDTH-1:0] wdata_dmem_i,
   input  logic                  w_en_dmem_i,
   input  logic [1:0]            size_dmem_i,
   output logic                  valid_mem_dmem_o,
   input  logic                  ready_mem_dmem_i,
   output logic [DATA_WIDTH-1:0] rdata_dmem_o,
   output logic                  err_dmem_o
);

   localparam int AW = $clog2(DEPTH);

   state_e          state_r;
   state_e          state_nxt_s;
   logic [63:0]     rdata_r;
   logic            err_r;
   logic [63:0]     mem_r [DEPTH];

   logic [AW-1:0]   idx_s;
   logic            unused_addr_s;
   logic            req_fire_s;
   logic            wr_en_s;
   logic            resp_gen_s;
   logic [7:0]      mask_s;
   logic [63:0]     wdata_sh_s;
   logic [63:0]     rword_s;
   logic [63:0]     rdata_al_s;
   logic            misalign_s;

   // Upper address bits are dropped so the array wraps modulo DEPTH*8 bytes
   assign idx_s         = addr_dmem_i[AW+2:3];
   assign unused_addr_s = ^addr_dmem_i[DATA_WIDTH-1:AW+3];

   assign ready_dmem_o  = (state_r == ST_IDLE) | ready_mem_dmem_i;
   assign req_fire_s    = valid_dmem_i & ready_dmem_o;
   assign wr_en_s       = req_fire_s & w_en_dmem_i & ~misalign_s;
   assign resp_gen_s    = req_fire_s & (~w_en_dmem_i | misalign_s);
   assign rword_s       = mem_r[idx_s];

   cprv_dmem_lane_align u_lane_align (
      .off_raw  (addr_dmem_i[2:0]),
      .size     (size_e'(size_dmem_i)),
      .wdata    (wdata_dmem_i),
      .rword    (rword_s),
      .mask     (mask_s),
      .wdata_sh (wdata_sh_s),
      .rdata_al (rdata_al_s),
      .misalign (misalign_s)
   );

   // Byte-lane write port; contents are intentionally left unreset
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         for (int i = 0; i < 8; i++) begin
            if (mask_s[i]) begin
               mem_r[idx_s][8*i +: 8] <= wdata_sh_s[8*i +: 8];
            end
         end
      end
   end

   // Response FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next state: a new response replaces a consumed one with no bubble
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (resp_gen_s) state_nxt_s = ST_RESP;
            else            state_nxt_s = ST_IDLE;
         end
         ST_RESP: begin
            if (!ready_mem_dmem_i) state_nxt_s = ST_RESP;
            else if (resp_gen_s)   state_nxt_s = ST_RESP;
            else                   state_nxt_s = ST_IDLE;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Response payload register, only loaded when a new response is accepted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_r <= 64'd0;
         err_r   <= 1'b0;
      end else if (resp_gen_s) begin
         rdata_r <= misalign_s ? 64'd0 : rdata_al_s;
         err_r   <= misalign_s;
      end
   end

   assign valid_mem_dmem_o = (state_r == ST_RESP);
   assign rdata_dmem_o     = rdata_r;
`ifdef CPRV_DMEM_MISALIGN_CHK_EN
   assign err_dmem_o       = err_r;
`else
   assign err_dmem_o       = 1'b0 & err_r;
`endif

endmodule
